// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader and the datapath side:
// FSM encoding, bus widths and the default no-op instruction.
package imem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_START = 2'd2,
        ST_RUN   = 2'd3
    } state_e;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 8;
    localparam int CNT_W   = 9;

    localparam logic [INSTR_W-1:0] NOP_DEFAULT = 8'h00;

    // Address width for a memory of the given depth, never below one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Instruction storage: synchronous write port for the loader, asynchronous
// read port so the single-cycle datapath sees mem[PC] with no latency.
module imem_ram #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 8,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Program loader and instruction server: accepts a byte stream into local
// memory while holding the CPU in reset, then serves mem[PC] during RUN.
module imem_loader
    import imem_pkg::*;
#(
    parameter int                 DEPTH     = 256,
    parameter int                 DATA_W    = INSTR_W,
    parameter logic [DATA_W-1:0]  NOP_INSTR = DATA_W'(NOP_DEFAULT)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              load_mode,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic [PC_W-1:0]   PC,
    output logic [DATA_W-1:0] instruction,
    output logic              cpu_reset,
    output logic [CNT_W-1:0]  load_count,
    output logic              overflow
);

    localparam int AW = addr_w(DEPTH);

    state_e            state_q;
    logic [AW-1:0]     wr_ptr_q;
    logic [CNT_W-1:0]  load_count_q;
    logic              overflow_q;
    logic              cpu_reset_q;

    logic              full;
    logic              xfer;
    logic [DATA_W-1:0] ram_rdata;

    assign full     = (load_count_q == CNT_W'(DEPTH));
    assign wr_ready = (state_q == ST_LOAD) && !full;
    assign xfer     = wr_valid && wr_ready;

    // Every entry into LOAD starts a fresh program: pointer, count and overflow clear.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            load_count_q <= '0;
            overflow_q   <= 1'b0;
            cpu_reset_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_mode) begin
                        state_q      <= ST_LOAD;
                        wr_ptr_q     <= '0;
                        load_count_q <= '0;
                        overflow_q   <= 1'b0;
                    end else begin
                        state_q <= ST_START;
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        wr_ptr_q     <= wr_ptr_q + AW'(1);
                        load_count_q <= load_count_q + CNT_W'(1);
                    end
                    if (wr_valid && full) begin
                        overflow_q <= 1'b1;
                    end
                    if (!load_mode) begin
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    state_q     <= ST_RUN;
                    cpu_reset_q <= 1'b0;
                end
                ST_RUN: begin
                    if (load_mode) begin
                        state_q      <= ST_LOAD;
                        cpu_reset_q  <= 1'b1;
                        wr_ptr_q     <= '0;
                        load_count_q <= '0;
                        overflow_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cpu_reset_q <= 1'b1;
                end
            endcase
        end
    end

    imem_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_ram (
        .clk   (CLK),
        .we    (xfer),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .raddr (PC[AW-1:0]),
        .rdata (ram_rdata)
    );

    // Stale memory beyond the loaded program is masked by the count, not cleared.
    always_comb begin
        instruction = NOP_INSTR;
        if ((state_q == ST_RUN) && ({1'b0, PC} < load_count_q)) begin
            instruction = ram_rdata;
        end
    end

    assign cpu_reset  = cpu_reset_q;
    assign load_count = load_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus randomized load/run
// rounds, all checked against a queue-based program model.
module tb_imem_loader;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       load_mode;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [7:0] PC;
    logic [7:0] instruction;
    logic       cpu_reset;
    logic [8:0] load_count;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: the bytes accepted in the latest load phase, and whether the CPU runs.
    logic [7:0] prog[$];
    bit         running;

    imem_loader dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .load_mode   (load_mode),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .PC          (PC),
        .instruction (instruction),
        .cpu_reset   (cpu_reset),
        .load_count  (load_count),
        .overflow    (overflow)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] exp_instr(input int pc);
        if (running && pc < prog.size()) return prog[pc];
        return 8'h00;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_fetch(input int pc, input string name);
        PC = 8'(pc);
        #1;
        n_tests++;
        if (instruction !== exp_instr(pc)) begin
            n_fail++;
            $display("FAIL %s pc=%0d got=%h exp=%h", name, pc, instruction, exp_instr(pc));
        end
    endtask

    task automatic go_run();
        load_mode = 1'b0;
        wr_valid  = 1'b0;
        tick();
        n_tests++;
        if (cpu_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL start_cpu_reset got=%b exp=1", cpu_reset);
        end
        check_fetch(0, "start_nop");
        tick();
        running = 1'b1;
        n_tests++;
        if (cpu_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL run_cpu_reset got=%b exp=0", cpu_reset);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; load_mode = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; PC = 8'h00;
        prog.delete(); running = 1'b0;
        tick(); tick();
        n_tests++;
        if ({cpu_reset, wr_ready, load_count, overflow, instruction} !== {1'b1, 1'b0, 9'd0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_state got cr=%b rdy=%b cnt=%0d ovf=%b ins=%h exp cr=1 rdy=0 cnt=0 ovf=0 ins=00",
                     cpu_reset, wr_ready, load_count, overflow, instruction);
        end
        #2 RESET = 1'b0;
    endtask

    task automatic test_stream_load();
        logic [7:0] bytes [3] = '{8'h41, 8'h82, 8'hC3};
        int not_ready = 0;
        load_mode = 1'b1;
        tick();
        prog.delete(); running = 1'b0;
        wr_valid = 1'b1;
        foreach (bytes[i]) begin
            wr_data = bytes[i];
            #1;
            if (wr_ready !== 1'b1) not_ready++;
            tick();
            prog.push_back(bytes[i]);
        end
        wr_valid = 1'b0;
        n_tests++;
        if (not_ready != 0) begin
            n_fail++;
            $display("FAIL stream_ready got=%0d_low_cycles exp=0", not_ready);
        end
        n_tests++;
        if (load_count !== 9'(prog.size())) begin
            n_fail++;
            $display("FAIL stream_count got=%0d exp=%0d", load_count, prog.size());
        end
        n_tests++;
        if (cpu_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_cpu_reset got=%b exp=1", cpu_reset);
        end
    endtask

    task automatic test_run_fetch();
        go_run();
        check_fetch(0, "run_pc0");
        check_fetch(1, "run_pc1");
        check_fetch(2, "run_pc2");
        check_fetch(3, "run_pc3");
        check_fetch(255, "run_pcff");
    endtask

    task automatic test_full_overflow();
        int not_ready = 0;
        load_mode = 1'b1;
        tick();
        prog.delete(); running = 1'b0;
        n_tests++;
        if ({cpu_reset, load_count} !== {1'b1, 9'd0}) begin
            n_fail++;
            $display("FAIL full_entry got cr=%b cnt=%0d exp cr=1 cnt=0", cpu_reset, load_count);
        end
        wr_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            wr_data = 8'($urandom);
            #1;
            if (wr_ready !== 1'b1) not_ready++;
            tick();
            prog.push_back(wr_data);
        end
        n_tests++;
        if (not_ready != 0) begin
            n_fail++;
            $display("FAIL full_ready_stream got=%0d_low_cycles exp=0", not_ready);
        end
        wr_data = ~prog[0];
        n_tests++;
        if ({wr_ready, load_count, overflow} !== {1'b0, 9'd256, 1'b0}) begin
            n_fail++;
            $display("FAIL full_reached got rdy=%b cnt=%0d ovf=%b exp rdy=0 cnt=256 ovf=0",
                     wr_ready, load_count, overflow);
        end
        tick();
        wr_valid = 1'b0;
        n_tests++;
        if ({load_count, overflow} !== {9'd256, 1'b1}) begin
            n_fail++;
            $display("FAIL full_overflow got cnt=%0d ovf=%b exp cnt=256 ovf=1", load_count, overflow);
        end
        go_run();
        check_fetch(0, "full_pc0");
        check_fetch(255, "full_pc255");
        for (int i = 0; i < 6; i++) check_fetch($urandom_range(1, 254), "full_rand");
    endtask

    task automatic test_reload_from_run();
        load_mode = 1'b1;
        tick();
        prog.delete(); running = 1'b0;
        n_tests++;
        if ({cpu_reset, load_count, overflow, wr_ready} !== {1'b1, 9'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reload got cr=%b cnt=%0d ovf=%b rdy=%b exp cr=1 cnt=0 ovf=0 rdy=1",
                     cpu_reset, load_count, overflow, wr_ready);
        end
        check_fetch(0, "reload_nop0");
        check_fetch(128, "reload_nop128");
    endtask

    task automatic test_async_reset();
        wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'($urandom);
            tick();
        end
        #3 RESET = 1'b1;
        #1;
        n_tests++;
        if ({cpu_reset, wr_ready, load_count} !== {1'b1, 1'b0, 9'd0}) begin
            n_fail++;
            $display("FAIL async_reset got cr=%b rdy=%b cnt=%0d exp cr=1 rdy=0 cnt=0",
                     cpu_reset, wr_ready, load_count);
        end
        prog.delete(); running = 1'b0;
        wr_valid = 1'b0;
        load_mode = 1'b0;
        #2 RESET = 1'b0;
        go_run();
        check_fetch(0, "empty_pc0");
        check_fetch(1, "empty_pc1");
        check_fetch(3, "empty_pc3");
    endtask

    task automatic test_toggle_valid();
        logic [7:0] data [3] = '{8'h10, 8'hEE, 8'h20};
        logic       vld  [3] = '{1'b1, 1'b0, 1'b1};
        load_mode = 1'b1;
        wr_valid  = 1'b0;
        tick();
        prog.delete(); running = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_valid = vld[i];
            wr_data  = data[i];
            tick();
            if (vld[i]) prog.push_back(data[i]);
        end
        wr_valid = 1'b0;
        n_tests++;
        if (load_count !== 9'd2) begin
            n_fail++;
            $display("FAIL toggle_count got=%0d exp=2", load_count);
        end
        go_run();
        check_fetch(0, "toggle_pc0");
        check_fetch(1, "toggle_pc1");
        check_fetch(2, "toggle_pc2");
    endtask

    // Random programs with gappy valid; the final byte is offered as load_mode falls.
    task automatic test_random_rounds();
        for (int r = 0; r < 6; r++) begin
            int n = $urandom_range(1, 40);
            load_mode = 1'b1;
            wr_valid  = 1'b0;
            tick();
            prog.delete(); running = 1'b0;
            for (int i = 0; i < n; i++) begin
                wr_valid = ($urandom_range(0, 3) != 0);
                wr_data  = 8'($urandom);
                if (i == n - 1) begin
                    wr_valid  = 1'b1;
                    load_mode = 1'b0;
                end
                tick();
                if (wr_valid) prog.push_back(wr_data);
            end
            wr_valid = 1'b0;
            n_tests++;
            if ({load_count, cpu_reset} !== {9'(prog.size()), 1'b1}) begin
                n_fail++;
                $display("FAIL rand_count r=%0d got cnt=%0d cr=%b exp cnt=%0d cr=1",
                         r, load_count, cpu_reset, prog.size());
            end
            tick();
            running = 1'b1;
            n_tests++;
            if (cpu_reset !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_run r=%0d cpu_reset got=%b exp=0", r, cpu_reset);
            end
            check_fetch(prog.size() - 1, "rand_last");
            check_fetch(prog.size(), "rand_past_end");
            for (int k = 0; k < 5; k++) check_fetch($urandom_range(0, 63), "rand_pc");
        end
    endtask

    initial begin
        test_reset();
        test_stream_load();
        test_run_fetch();
        test_full_overflow();
        test_reload_from_run();
        test_async_reset();
        test_toggle_valid();
        test_random_rounds();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
